// File: rtl/spi_pkg.sv
// Shared constants and FSM state encoding for the SPI shift engine.
package spi_pkg;

    localparam int unsigned SPI_MAX_CHAR_DFLT      = 32;
    localparam int unsigned SPI_CHAR_LEN_BITS_DFLT = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_shift_if.sv
// Control, data and serial signals between the SPI shift engine and its surroundings.
interface spi_shift_if
    import spi_pkg::*;
#(
    parameter int unsigned SPI_MAX_CHAR      = SPI_MAX_CHAR_DFLT,
    parameter int unsigned SPI_CHAR_LEN_BITS = SPI_CHAR_LEN_BITS_DFLT
);

    logic                         go;
    logic [SPI_CHAR_LEN_BITS-1:0] len;
    logic                         lsb;
    logic                         tx_negedge;
    logic                         rx_negedge;
    logic                         cpol_0;
    logic                         cpol_1;
    logic [SPI_MAX_CHAR-1:0]      p_in;
    logic                         miso;
    logic                         tip;
    logic                         last;
    logic                         done;
    logic [SPI_MAX_CHAR-1:0]      p_out;
    logic                         mosi;

    modport master (
        output go, len, lsb, tx_negedge, rx_negedge, cpol_0, cpol_1, p_in, miso,
        input  tip, last, done, p_out, mosi
    );

    modport slave (
        input  go, len, lsb, tx_negedge, rx_negedge, cpol_0, cpol_1, p_in, miso,
        output tip, last, done, p_out, mosi
    );

endinterface

// File: rtl/spi_bit_idx.sv
// Maps a transfer bit count to a word bit index for LSB-first or MSB-first ordering.
module spi_bit_idx #(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned IDX_W = 5
) (
    input  logic             i_lsb,
    input  logic [CNT_W-1:0] i_n,
    input  logic [CNT_W-1:0] i_cnt,
    output logic [IDX_W-1:0] o_idx_c
);

    logic [CNT_W-1:0] w_rev;

    assign w_rev   = i_n - i_cnt - CNT_W'(1);
    assign o_idx_c = i_lsb ? IDX_W'(i_cnt) : IDX_W'(w_rev);

endmodule

// File: rtl/spi_shift.sv
// SPI shift engine: serialises p_in onto mosi and assembles p_out from miso on sclk strobes.
// LSB-first ordering is available only when SPI_LSB_FIRST_EN is defined.
module spi_shift
    import spi_pkg::*;
#(
    parameter int unsigned SPI_MAX_CHAR      = SPI_MAX_CHAR_DFLT,
    parameter int unsigned SPI_CHAR_LEN_BITS = SPI_CHAR_LEN_BITS_DFLT
) (
    input  logic       wb_clk_in,
    input  logic       wb_rst_n,
    spi_shift_if.slave bus
);

    localparam int unsigned CNT_W = SPI_CHAR_LEN_BITS + 1;
    localparam int unsigned IDX_W = SPI_CHAR_LEN_BITS;

    spi_state_e              r_state, w_state_nxt;
    logic [SPI_MAX_CHAR-1:0] r_word, w_word_nxt;
    logic [SPI_MAX_CHAR-1:0] r_p_out, w_p_out_nxt;
    logic [CNT_W-1:0]        r_n, w_n_nxt;
    logic [CNT_W-1:0]        r_tx_cnt, w_tx_cnt_nxt;
    logic [CNT_W-1:0]        r_rx_cnt, w_rx_cnt_nxt;
    logic                    r_mosi, w_mosi_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_last, w_last_nxt;
    logic                    r_tip;
    logic                    w_lsb;
    logic                    w_tx_edge;
    logic                    w_rx_edge;
    logic [IDX_W-1:0]        w_tx_idx;
    logic [IDX_W-1:0]        w_rx_idx;

`ifdef SPI_LSB_FIRST_EN
    logic r_lsb, w_lsb_nxt;
    assign w_lsb = r_lsb;
`else
    logic w_unused_lsb;
    assign w_lsb        = 1'b0;
    assign w_unused_lsb = bus.lsb;
`endif

    assign w_tx_edge = bus.tx_negedge ? bus.cpol_1 : bus.cpol_0;
    assign w_rx_edge = bus.rx_negedge ? bus.cpol_1 : bus.cpol_0;

    spi_bit_idx #(.CNT_W(CNT_W), .IDX_W(IDX_W)) u_tx_idx (
        .i_lsb   (w_lsb),
        .i_n     (r_n),
        .i_cnt   (r_tx_cnt),
        .o_idx_c (w_tx_idx)
    );

    spi_bit_idx #(.CNT_W(CNT_W), .IDX_W(IDX_W)) u_rx_idx (
        .i_lsb   (w_lsb),
        .i_n     (r_n),
        .i_cnt   (r_rx_cnt),
        .o_idx_c (w_rx_idx)
    );

    // Next-state and datapath updates; tx and rx edges in one cycle are both honoured.
    always_comb begin
        w_state_nxt  = r_state;
        w_word_nxt   = r_word;
        w_p_out_nxt  = r_p_out;
        w_n_nxt      = r_n;
        w_tx_cnt_nxt = r_tx_cnt;
        w_rx_cnt_nxt = r_rx_cnt;
        w_mosi_nxt   = r_mosi;
        w_done_nxt   = 1'b0;
`ifdef SPI_LSB_FIRST_EN
        w_lsb_nxt    = r_lsb;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.go) begin
                    w_word_nxt   = bus.p_in;
                    w_n_nxt      = (bus.len == '0) ? CNT_W'(SPI_MAX_CHAR) : CNT_W'(bus.len);
                    w_tx_cnt_nxt = '0;
                    w_rx_cnt_nxt = '0;
                    w_p_out_nxt  = '0;
                    w_state_nxt  = ST_XFER;
`ifdef SPI_LSB_FIRST_EN
                    w_lsb_nxt    = bus.lsb;
`endif
                end
            end
            ST_XFER: begin
                if (w_tx_edge && (r_tx_cnt < r_n)) begin
                    w_mosi_nxt   = r_word[w_tx_idx];
                    w_tx_cnt_nxt = r_tx_cnt + CNT_W'(1);
                end
                if (w_rx_edge && (r_rx_cnt < r_n)) begin
                    w_p_out_nxt[w_rx_idx] = bus.miso;
                    w_rx_cnt_nxt          = r_rx_cnt + CNT_W'(1);
                    if (w_rx_cnt_nxt == r_n) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_last_nxt = (w_state_nxt == ST_XFER) && (w_tx_cnt_nxt == w_n_nxt);
    end

    always_ff @(posedge wb_clk_in or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state  <= ST_IDLE;
            r_word   <= '0;
            r_p_out  <= '0;
            r_n      <= '0;
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
            r_mosi   <= 1'b0;
            r_done   <= 1'b0;
            r_last   <= 1'b0;
            r_tip    <= 1'b0;
`ifdef SPI_LSB_FIRST_EN
            r_lsb    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_word   <= w_word_nxt;
            r_p_out  <= w_p_out_nxt;
            r_n      <= w_n_nxt;
            r_tx_cnt <= w_tx_cnt_nxt;
            r_rx_cnt <= w_rx_cnt_nxt;
            r_mosi   <= w_mosi_nxt;
            r_done   <= w_done_nxt;
            r_last   <= w_last_nxt;
            r_tip    <= (w_state_nxt == ST_XFER);
`ifdef SPI_LSB_FIRST_EN
            r_lsb    <= w_lsb_nxt;
`endif
        end
    end

    assign bus.tip   = r_tip;
    assign bus.last  = r_last;
    assign bus.done  = r_done;
    assign bus.p_out = r_p_out;
    assign bus.mosi  = r_mosi;

endmodule

// File: doc/spi_shift.md
SPI_SHIFT -- requirements
Module: spi_shift

Interface
REQ-001 SHALL have parameter SPI_MAX_CHAR, default 32, maximum transfer length in bits.
REQ-002 SHALL have parameter SPI_CHAR_LEN_BITS, default 5, width of len (log2 of SPI_MAX_CHAR).
REQ-003 SHALL have ports: wb_clk_in  in  1  system clock; all logic on rising edge.
REQ-004 wb_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 go  in  1  start request, level, sampled only while idle.
REQ-006 len  in  SPI_CHAR_LEN_BITS  bits per transfer; 0 means SPI_MAX_CHAR.
REQ-007 lsb  in  1  1 = LSB-first, 0 = MSB-first.
REQ-008 tx_negedge / rx_negedge  in  1 each  drive MOSI / sample MISO on falling (1) or rising (0) sclk edge.
REQ-009 cpol_0 / cpol_1  in  1 each  one-cycle strobes from the clock generator marking sclk rising / falling edges.
REQ-010 p_in  in  SPI_MAX_CHAR  transmit word; miso  in  1  serial input.
REQ-011 tip  out  1  transfer in progress, fed to the clock generator.
REQ-012 last  out  1  final bit driven, fed to the clock generator's last_clk.
REQ-013 done  out  1  one-cycle completion pulse; p_out  out  SPI_MAX_CHAR  received word; mosi  out  1  serial output.

Function
REQ-014 States SHALL be IDLE and XFER; tip = (state == XFER).
REQ-015 IDLE with go=1 SHALL latch p_in, lsb, len (0 -> SPI_MAX_CHAR) into N, clear tx_cnt/rx_cnt, enter XFER next cycle.
REQ-016 tx edge = tx_negedge ? cpol_1 : cpol_0; rx edge = rx_negedge ? cpol_1 : cpol_0; both evaluated only in XFER.
REQ-017 On tx edge with tx_cnt < N: mosi SHALL take bit (lsb ? tx_cnt : N-1-tx_cnt) of latched word; tx_cnt increments.
REQ-018 On rx edge with rx_cnt < N: miso SHALL be written to p_out bit (lsb ? rx_cnt : N-1-rx_cnt); rx_cnt increments.
REQ-019 tx and rx edges in the same cycle SHALL both be processed.
REQ-020 last SHALL be 1 in XFER when tx_cnt == N, else 0.
REQ-021 Cycle after the rx edge making rx_cnt == N: state -> IDLE, tip -> 0, done = 1 for exactly one cycle.
REQ-022 go during XFER SHALL be ignored; go held high across done SHALL start the next transfer the cycle after tip falls.
REQ-023 p_out bits at index >= N SHALL be cleared at transfer start; p_out holds its value in IDLE until next start.
REQ-024 mosi SHALL hold its last value between tx edges and in IDLE.
REQ-025 Strobes in IDLE SHALL have no effect.

Reset
REQ-026 wb_rst_n low SHALL immediately force IDLE, tip=0, last=0, done=0, mosi=0, p_out=0, counters=0, mid-transfer included.
REQ-027 Release SHALL be synchronous-safe: first go sampled on the first rising edge after deassertion.

Configuration
REQ-028 Macro SPI_LSB_FIRST_EN: defined -> lsb input honoured as REQ-017/018; undefined -> MSB-first only, lsb ignored, no lsb register.

Structure
REQ-029 SPI_MAX_CHAR, SPI_CHAR_LEN_BITS defaults and state encodings SHALL live in shared package spi_pkg.
REQ-030 Bit-index selection (lsb/N/count -> index) SHALL be sub-module spi_bit_idx, instanced for tx and rx.

Verification
REQ-031 len=8, lsb=0, tx_negedge=1, rx_negedge=0, p_in=0xA5, miso loopback -> mosi 1,0,1,0,0,1,0,1; p_out=0x000000A5; done one pulse.
REQ-032 len=0, lsb=1, p_in=0x80000001, miso tied 1 -> 32 tx edges, mosi first bit 1, last high after 32nd tx edge, p_out=0xFFFFFFFF.
REQ-033 go pulsed mid-transfer (len=4) -> ignored; tip stays 1; exactly 4 bits; one done.
REQ-034 wb_rst_n low after 3 of 8 bits -> same-instant tip=0, p_out=0, mosi=0; next go restarts bit 0.
REQ-035 Coincident tx/rx strobe (tx_negedge=rx_negedge=0), len=2, p_in=0x2, miso=1 -> mosi 1,0; p_out=0x3; done once.
REQ-036 Build without SPI_LSB_FIRST_EN, lsb=1, p_in=0x01, len=8 -> MSB-first: mosi 0×7 then 1.
